// File: rtl/quadrature_decoder.sv
// Quadrature encoder front end: per-channel synchroniser and glitch filter, Gray-phase
// decode into a step/dir pair, sticky illegal-jump flag. Define QUAD_X1_EN for x1 decode.
module quadrature_decoder #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enc_a,
  input  logic enc_b,
  input  logic err_clr,
  output logic step,
  output logic dir,
  output logic err
);

  typedef enum logic [1:0] {SYNC, LOAD, RUN} state_t;

  localparam logic [3:0] CNT_LAST = 4'(FILTER_CYCLES - 1);

  state_t      state_q, state_d;
  logic        sync_cnt_q, sync_cnt_d;
  logic [1:0]  sync1_q, sync1_d;
  logic [1:0]  sync2_q, sync2_d;
  logic [1:0]  filt_q, filt_d;
  logic [1:0]  prev_q, prev_d;
  logic [3:0]  cnt_a_q, cnt_a_d;
  logic [3:0]  cnt_b_q, cnt_b_d;
  logic        step_q, step_d;
  logic        dir_q, dir_d;
  logic        err_q, err_d;
  logic [4:0]  fa_c, fb_c;
  logic        up_c;

  // Returns {toggle, next_count} for one channel's mismatch filter.
  function automatic logic [4:0] filt_next(input logic s, input logic f, input logic [3:0] cnt);
    if (s == f)
      return 5'd0;
    else if (cnt == CNT_LAST)
      return {1'b1, 4'd0};
    else
      return {1'b0, cnt + 4'd1};
  endfunction

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    sync1_d    = {enc_a, enc_b};
    sync2_d    = sync1_q;
    filt_d     = filt_q;
    prev_d     = prev_q;
    cnt_a_d    = 4'd0;
    cnt_b_d    = 4'd0;
    step_d     = 1'b0;
    dir_d      = dir_q;
    err_d      = err_q & ~err_clr;
    fa_c       = 5'd0;
    fb_c       = 5'd0;
    up_c       = 1'b0;
    case (state_q)
      SYNC: begin
        sync_cnt_d = 1'b1;
        if (sync_cnt_q)
          state_d = LOAD;
      end
      LOAD: begin
        filt_d  = sync2_q;
        prev_d  = sync2_q;
        state_d = RUN;
      end
      RUN: begin
        fa_c    = filt_next(sync2_q[1], filt_q[1], cnt_a_q);
        fb_c    = filt_next(sync2_q[0], filt_q[0], cnt_b_q);
        filt_d  = filt_q ^ {fa_c[4], fb_c[4]};
        cnt_a_d = fa_c[3:0];
        cnt_b_d = fb_c[3:0];
        // While a step is on the output, decode waits a cycle so step never spans two cycles.
        if (!step_q && (filt_q != prev_q)) begin
          prev_d = filt_q;
          if (&(filt_q ^ prev_q)) begin
            err_d = 1'b1;
          end else begin
            up_c = (filt_q == {prev_q[0], ~prev_q[1]});
`ifdef QUAD_X1_EN
            step_d = up_c ? (prev_q == 2'b10) : (prev_q == 2'b00);
`else
            step_d = 1'b1;
`endif
            if (step_d)
              dir_d = up_c;
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SYNC;
      sync_cnt_q <= 1'b0;
      sync1_q    <= 2'b00;
      sync2_q    <= 2'b00;
      filt_q     <= 2'b00;
      prev_q     <= 2'b00;
      cnt_a_q    <= 4'd0;
      cnt_b_q    <= 4'd0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      filt_q     <= filt_d;
      prev_q     <= prev_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
    end
  end

  assign step = step_q;
  assign dir  = dir_q;
  assign err  = err_q;

endmodule
